// File: rtl/cnn_pkg.sv
// Shared types and default sizes for the convolution array datapath.
// Holds the operand sequencer state encoding and the PE timing constant that
// the processing_element and the sequencer must agree on.
package cnn_pkg;

  // Default datapath widths: 8-bit operands, 32-bit accumulator, 8-bit buffer address
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 8;

  // Cycles from the last PE enable until the PE accumulator output is final
  localparam int PE_LATENCY_CYCLES = 2;

  // Operand sequencer job states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Address generator for one sequencer job: activation pointer advancing by a
// stride, weight pointer advancing by one, and a pair counter with last flag.
// Pointers wrap silently modulo 2^ADDR_W.
module seq_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] a_stride_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] a_ptr_o,
  output logic [ADDR_W-1:0] b_ptr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;

  // Next-state: load from the bases, or advance one pair per step
  always_comb begin
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    count_d = count_q;
    if (load_i) begin
      a_ptr_d = a_base_i;
      b_ptr_d = b_base_i;
      count_d = '0;
    end else if (step_i) begin
      a_ptr_d = a_ptr_q + a_stride_i;
      b_ptr_d = b_ptr_q + ADDR_W'(1);
      count_d = count_q + ADDR_W'(1);
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      count_q <= '0;
    end else begin
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      count_q <= count_d;
    end
  end

  // The current pair is the final one of the job (only meaningful when len != 0)
  assign last_o  = (count_q == (len_i - ADDR_W'(1)));
  assign a_ptr_o = a_ptr_q;
  assign b_ptr_o = b_ptr_q;

endmodule

// File: rtl/pe_operand_sequencer.sv
// Feeds one MAC processing element: clears it, streams len operand pairs from
// the activation/weight buffers, waits out the PE latency and captures the result.
// Latency len+PE_LATENCY+3 cycles from start to o_valid; the result is held until i_ready.
module pe_operand_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PE_LATENCY = PE_LATENCY_CYCLES
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [ADDR_W-1:0] i_a_base,
  input  logic [ADDR_W-1:0] i_a_stride,
  input  logic [ADDR_W-1:0] i_b_base,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_a_addr,
  output logic [ADDR_W-1:0] o_b_addr,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic [DATA_W-1:0] i_b_data,
  output logic [DATA_W-1:0] o_pe_a,
  output logic [DATA_W-1:0] o_pe_b,
  output logic              o_pe_enable,
  output logic              o_pe_clear,
  input  logic [ACC_W-1:0]  i_pe_result,
  input  logic              i_pe_overflow,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_overflow
);

  // Drain counter runs 0..PE_LATENCY, i.e. PE_LATENCY+1 cycles in DRAIN
  localparam int DRAIN_W = $clog2(PE_LATENCY + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LATENCY);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] a_stride_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [DRAIN_W-1:0] drain_q;
  logic              busy_q;
  logic              rd_en_q;
  logic              pe_clear_q;
  logic              pe_en_q;
  logic              valid_q;
  logic [ACC_W-1:0]  result_q;
  logic              ovf_q;

  logic              gen_load;
  logic              gen_step;
  logic              gen_last;
  logic [ADDR_W-1:0] a_ptr;
  logic [ADDR_W-1:0] b_ptr;

  // Pointers are loaded during CLEAR so the first FETCH cycle presents the bases
  assign gen_load = (state_q == ST_CLEAR);
  assign gen_step = (state_q == ST_FETCH);

  seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i      (clk),
    .rst_ni     (i_reset),
    .load_i     (gen_load),
    .step_i     (gen_step),
    .a_base_i   (a_base_q),
    .a_stride_i (a_stride_q),
    .b_base_i   (b_base_q),
    .len_i      (len_q),
    .a_ptr_o    (a_ptr),
    .b_ptr_o    (b_ptr),
    .last_o     (gen_last)
  );

  // Job FSM with registered control outputs and result capture
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      a_base_q   <= '0;
      a_stride_q <= '0;
      b_base_q   <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      pe_clear_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            len_q      <= i_len;
            a_base_q   <= i_a_base;
            a_stride_q <= i_a_stride;
            b_base_q   <= i_b_base;
            busy_q     <= 1'b1;
            pe_clear_q <= 1'b1;
            state_q    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          pe_clear_q <= 1'b0;
          drain_q    <= '0;
          if (len_q != '0) begin
            rd_en_q <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_FETCH: begin
          // Exactly len read cycles: stop after the one carrying the last pair
          if (gen_last) begin
            rd_en_q <= 1'b0;
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            result_q <= i_pe_result;
            ovf_q    <= i_pe_overflow;
            valid_q  <= 1'b1;
            state_q  <= ST_OUTPUT;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        ST_OUTPUT: begin
          // Captured values stay on the port after the handshake
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q     <= 1'b0;
          rd_en_q    <= 1'b0;
          pe_clear_q <= 1'b0;
          valid_q    <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // PE enable follows the read strobe by one cycle to line up with buffer data
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      pe_en_q <= 1'b0;
    end else begin
      pe_en_q <= rd_en_q;
    end
  end

  assign o_busy      = busy_q;
  assign o_rd_en     = rd_en_q;
  assign o_a_addr    = a_ptr;
  assign o_b_addr    = b_ptr;
  assign o_pe_a      = i_a_data;
  assign o_pe_b      = i_b_data;
  assign o_pe_enable = pe_en_q;
  assign o_pe_clear  = pe_clear_q;
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_overflow  = ovf_q;

endmodule
